exp_max_arbiter: RTL and testbench
==================================

// Module: exp_max_arbiter
// PURPOSE
// Round-robin arbiter that shares one pipelined unsigned_max exponent-reduction
// unit between NUM_REQ MX quantiser lanes. It accepts one exponent block per
// cycle from a granted lane and drives it into the shared unit. It tracks each
// in-flight block with an id pipeline matched to the unit latency, then returns
// each shared-exponent result to its own lane through a valid/ready response
// register.
// PARAMETERS
// WIDTH    8   exponent width in bits
// LENGTH   32  exponents per block (matches unsigned_max length)
// NUM_REQ  4   number of requesting lanes, >=2
// LATENCY  1   cycles from o_unit_exps to i_unit_e_max (0 = combinational unit)
// PORTS
// i_clk          in   1                      clock
// i_rst_n        in   1                      async reset, active-low
// i_req_valid    in   NUM_REQ                lane r presents a block
// i_req_exps     in   [NUM_REQ][LENGTH][WIDTH]  per-lane exponent blocks
// o_req_ready    out  NUM_REQ                one-hot accept (grant) for this cycle
// o_unit_exps    out  [LENGTH][WIDTH]        block driven to shared unsigned_max
// i_unit_e_max   in   WIDTH                  result from shared unsigned_max
// o_rsp_valid    out  NUM_REQ                lane r result available
// o_rsp_e_max    out  [NUM_REQ][WIDTH]       per-lane shared exponent
// i_rsp_ready    in   NUM_REQ                lane r consumes its result
// o_idle         out  1                      no block in flight or held
// BEHAVIOUR
// - Reset: i_rst_n is asynchronous, active-low; the clock is i_clk.
//   Reset clears o_rsp_valid, o_rsp_e_max, busy[], the id pipeline and the
//   rr pointer (=0). o_idle=1.
// - busy[r] is set on accept (i_req_valid[r] & o_req_ready[r]).
//   It is cleared on the response handshake (o_rsp_valid[r] & i_rsp_ready[r]).
//   Each lane has at most one block outstanding (issued or held).
// - Eligibility: elig[r] = i_req_valid[r] & ~busy[r].
//   o_req_ready is combinational: the one-hot first eligible lane searching
//   from ptr upward, with wrap-around. It is all-zero if nothing is eligible.
// - Pointer: after a grant to lane g, ptr <= (g+1) mod NUM_REQ. It is unchanged
//   when there is no grant.
// - o_unit_exps = i_req_exps[granted lane]; all zeros when there is no grant
//   (deterministic, power).
// - Id pipeline: LATENCY stages of {vld, id[$clog2(NUM_REQ)-1:0]}, shifted
//   every cycle, no stall. The stage-0 input is {grant_any, grant_id}.
//   The pipeline output aligns with i_unit_e_max.
//   LATENCY=0: the stage input is used directly.
// - Capture: when the aligned vld=1 with id=k, then on the clock edge
//   o_rsp_e_max[k] <= i_unit_e_max and o_rsp_valid[k] <= 1.
//   Overwrite cannot occur because busy[k] blocks reissue.
//   Capture of lane k and a response handshake on lane j!=k in the same cycle
//   are independent.
// - Accept-to-o_rsp_valid latency = LATENCY+1 cycles. Throughput is 1
//   block/cycle across lanes.
// - A handshake on lane r and i_req_valid[r] in the same cycle: busy[r] is still
//   1, so no grant that cycle. The earliest re-grant is the next cycle.
// - o_rsp_e_max[r] holds its value after the handshake until the next capture.
// - o_idle = ~|busy.
// - Reset mid-operation: in-flight ids and held results are discarded. The
//   shared unit output is ignored until new grants propagate.
// - Arithmetic: none on data. The id width is $clog2(NUM_REQ). The ptr wraps
//   at NUM_REQ (non-power-of-2 NUM_REQ supported).
// TESTING
// - Reset, then idle: o_req_ready=0, o_rsp_valid=0, o_idle=1, o_unit_exps=0.
// - Single lane: lane 2 valid with exps{0..31}=i, rsp_ready=1 ->
//   o_req_ready=4'b0100, o_rsp_valid[2] at +LATENCY+1, e_max=31,
//   no re-grant while busy.
// - All 4 lanes valid continuously, rsp_ready=1 -> grants 0,1,2,3 in order,
//   then the lane freed earliest is re-granted. No lane is starved
//   (any lane is granted within NUM_REQ cycles of becoming eligible).
// - Backpressure: lane 1 rsp_ready=0 for 10 cycles -> o_rsp_valid[1] and
//   e_max held stable; lane 1 is never re-granted. The other lanes keep
//   1 block/cycle.
// - Sweep LATENCY in {0,1,2,5} with a reference unsigned_max model ->
//   every returned e_max equals the max of that lane's block.
// - Assert i_rst_n=0 with 3 blocks in flight -> all outputs cleared
//   immediately. After reset release, no stale o_rsp_valid appears.

Source files
------------

// File: rtl/exp_max_arbiter_if.sv
// Lane request/response bundle and shared-unit connection for exp_max_arbiter.
interface exp_max_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int LENGTH  = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ-1:0][LENGTH-1:0][WIDTH-1:0] req_exps;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [LENGTH-1:0][WIDTH-1:0]              unit_exps;
    logic [WIDTH-1:0]                          unit_e_max;
    logic [NUM_REQ-1:0]                        rsp_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0]             rsp_e_max;
    logic [NUM_REQ-1:0]                        rsp_ready;
    logic                                      idle;

    // master side is the quantiser lanes together with the shared unsigned_max unit
    modport master (
        output req_valid, req_exps, unit_e_max, rsp_ready,
        input  req_ready, unit_exps, rsp_valid, rsp_e_max, idle
    );

    modport slave (
        input  req_valid, req_exps, unit_e_max, rsp_ready,
        output req_ready, unit_exps, rsp_valid, rsp_e_max, idle
    );
endinterface

// File: rtl/exp_max_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned_max unit between NUM_REQ
// MX quantiser lanes. A lane id travels alongside each block so the result
// can be parked in that lane's response register until the lane takes it.
module exp_max_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LENGTH  = 32,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1
) (
    input logic              i_clk,
    input logic              i_rst_n,
    exp_max_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    logic [NUM_REQ-1:0]            busy;
    logic [NUM_REQ-1:0]            elig;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0][WIDTH-1:0] rsp_e_max;
    logic [NUM_REQ-1:0]            rsp_hs;
    id_t                           ptr;
    id_t                           grant_id;
    logic                          grant_any;
    tag_t                          tag_in;
    tag_t                          tag_out;

    // Adds an offset to a lane index, wrapping at NUM_REQ (works for any NUM_REQ).
    function automatic id_t wrap_add(input id_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return id_t'(sum);
    endfunction

    // A lane with a block issued or a result held may not be granted again.
    assign elig   = bus.req_valid & ~busy;
    assign rsp_hs = rsp_valid & bus.rsp_ready;

    // Pick the first eligible lane searching upward from ptr with wrap-around.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && elig[wrap_add(ptr, i)]) begin
                grant_any = 1'b1;
                grant_id  = wrap_add(ptr, i);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Move priority to the lane after the one just granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= wrap_add(grant_id, 1);
        end
    end

    assign bus.req_ready = grant;
    // Idle cycles drive zeros so the shared unit sees no toggling.
    assign bus.unit_exps = grant_any ? bus.req_exps[grant_id] : '0;
    assign tag_in        = {grant_any, grant_id};

    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign tag_out = tag_in;
        end else begin : g_pipe
            tag_t stage [LATENCY];

            // Shift the lane id in lockstep with the shared unit; it never stalls.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        stage[k] <= '0;
                    end
                end else begin
                    stage[0] <= tag_in;
                    for (int k = 1; k < LATENCY; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign tag_out = stage[LATENCY-1];
        end
    endgenerate

    // Per-lane bookkeeping: mark busy on accept, park the returning result, release on handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy      <= '0;
            rsp_valid <= '0;
            rsp_e_max <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (grant[r]) begin
                    busy[r] <= 1'b1;
                end else if (rsp_hs[r]) begin
                    busy[r] <= 1'b0;
                end
                if (tag_out.vld && (tag_out.id == id_t'(r))) begin
                    rsp_valid[r] <= 1'b1;
                    rsp_e_max[r] <= bus.unit_e_max;
                end else if (rsp_hs[r]) begin
                    rsp_valid[r] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_e_max = rsp_e_max;
    assign bus.idle      = ~|busy;
endmodule

// File: tb/tb_exp_max_arbiter.sv
// Bench for exp_max_arbiter: four instances at LATENCY 0,1,2,5 share one
// stimulus stream, each checked every cycle against a transaction-level model.
module tb_exp_max_arbiter;
    localparam int W  = 8;
    localparam int L  = 32;
    localparam int N  = 4;
    localparam int NI = 4;

    typedef logic [N-1:0][L-1:0][W-1:0] blocks_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] rready;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp_valid;
    } vec_t;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            default: return 5;
        endcase
    endfunction

    function automatic logic [W-1:0] blk_max(input logic [L-1:0][W-1:0] b);
        logic [W-1:0] m;
        m = '0;
        for (int j = 0; j < L; j++) begin
            if (b[j] > m) m = b[j];
        end
        return m;
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] rsp_ready;
    blocks_t      req_exps;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]          ready_w [NI];
    logic [L-1:0][W-1:0]   uexps_w [NI];
    logic [N-1:0]          rspv_w  [NI];
    logic [N-1:0][W-1:0]   emax_w  [NI];
    logic                  idle_w  [NI];

    // Free-running clock
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_lat
            localparam int LAT = lat_of(gi);

            exp_max_arbiter_if #(.WIDTH(W), .LENGTH(L), .NUM_REQ(N)) bus ();

            assign bus.req_valid = req_valid;
            assign bus.req_exps  = req_exps;
            assign bus.rsp_ready = rsp_ready;

            exp_max_arbiter #(.WIDTH(W), .LENGTH(L), .NUM_REQ(N), .LATENCY(LAT)) dut (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .bus     (bus)
            );

            // Reference shared unsigned_max unit with LAT cycles of delay
            if (LAT == 0) begin : g_comb
                assign bus.unit_e_max = blk_max(bus.unit_exps);
            end else begin : g_seq
                logic [W-1:0] pipe [LAT];
                always @(posedge clk) begin
                    pipe[0] <= blk_max(bus.unit_exps);
                    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
                end
                assign bus.unit_e_max = pipe[LAT-1];
            end

            assign ready_w[gi] = bus.req_ready;
            assign uexps_w[gi] = bus.unit_exps;
            assign rspv_w[gi]  = bus.rsp_valid;
            assign emax_w[gi]  = bus.rsp_e_max;
            assign idle_w[gi]  = bus.idle;
        end
    endgenerate

    // Transaction model: per-lane outstanding flag, countdown to result, result value
    logic [N-1:0]        m_busy  [NI];
    logic [N-1:0]        m_valid [NI];
    logic [N-1:0][W-1:0] m_emax  [NI];
    logic [N-1:0][W-1:0] m_pend  [NI];
    int                  m_ptr   [NI];
    int                  m_cnt   [NI][N];

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear(input int i);
        m_busy[i]  = '0;
        m_valid[i] = '0;
        m_emax[i]  = '0;
        m_pend[i]  = '0;
        m_ptr[i]   = 0;
        for (int r = 0; r < N; r++) m_cnt[i][r] = 0;
    endtask

    function automatic int predict_grant(input int i);
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr[i] + k) % N;
            if (req_valid[r] && !m_busy[i][r]) return r;
        end
        return -1;
    endfunction

    // Compare every instance with its model, then advance the model across the coming edge
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int                  g;
            logic [N-1:0]        exp_ready;
            logic [L-1:0][W-1:0] exp_u;
            logic [N-1:0]        hs;
            string               tag;
            if (!rst_n) model_clear(i);
            g         = predict_grant(i);
            exp_ready = '0;
            exp_u     = '0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                exp_u        = req_exps[g];
            end
            tag = $sformatf("lat%0d", lat_of(i));
            check_output({tag, " req_ready"}, ready_w[i], exp_ready);
            check_output({tag, " unit_exps"}, uexps_w[i], exp_u);
            check_output({tag, " rsp_valid"}, rspv_w[i], m_valid[i]);
            check_output({tag, " rsp_e_max"}, emax_w[i], m_emax[i]);
            check_output({tag, " idle"}, idle_w[i], ~|m_busy[i]);
            if (rst_n) begin
                hs         = m_valid[i] & rsp_ready;
                m_valid[i] = m_valid[i] & ~hs;
                m_busy[i]  = m_busy[i] & ~hs;
                if (g >= 0) begin
                    m_busy[i][g] = 1'b1;
                    m_ptr[i]     = (g + 1) % N;
                    m_cnt[i][g]  = lat_of(i) + 1;
                    m_pend[i][g] = blk_max(req_exps[g]);
                end
                for (int r = 0; r < N; r++) begin
                    if (m_cnt[i][r] > 0) begin
                        m_cnt[i][r]--;
                        if (m_cnt[i][r] == 0) begin
                            m_valid[i][r] = 1'b1;
                            m_emax[i][r]  = m_pend[i][r];
                        end
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs just after the edge, then check at the falling edge
    task automatic apply_stimulus(input logic rst, input logic [N-1:0] v, input logic [N-1:0] rr,
                                  input blocks_t ex);
        @(posedge clk);
        #1;
        rst_n     = rst;
        req_valid = v;
        rsp_ready = rr;
        req_exps  = ex;
        @(negedge clk);
        model_step();
    endtask

    blocks_t zero_exps;
    blocks_t ramp_exps;
    blocks_t pat_exps;
    blocks_t rnd_exps;
    vec_t    rr_tab [8];

    initial begin
        // Round-robin table for the LATENCY=1 instance: all lanes valid, responses always taken
        rr_tab[0] = '{4'hF, 4'hF, 4'b0001, 4'b0000};
        rr_tab[1] = '{4'hF, 4'hF, 4'b0010, 4'b0000};
        rr_tab[2] = '{4'hF, 4'hF, 4'b0100, 4'b0001};
        rr_tab[3] = '{4'hF, 4'hF, 4'b1000, 4'b0010};
        rr_tab[4] = '{4'hF, 4'hF, 4'b0001, 4'b0100};
        rr_tab[5] = '{4'hF, 4'hF, 4'b0010, 4'b1000};
        rr_tab[6] = '{4'hF, 4'hF, 4'b0100, 4'b0001};
        rr_tab[7] = '{4'hF, 4'hF, 4'b1000, 4'b0010};

        zero_exps = '0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < L; j++) begin
                ramp_exps[r][j] = W'(j);
                pat_exps[r][j]  = W'(r * 50 + j * 3);
            end
        end

        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_exps  = '0;
        for (int i = 0; i < NI; i++) model_clear(i);
        #2;
        rst_n = 1'b0;

        // Reset and idle
        apply_stimulus(1'b0, 4'b0000, 4'b0000, zero_exps);
        apply_stimulus(1'b0, 4'b0000, 4'b0000, zero_exps);
        check_output("reset idle", idle_w[1], 1'b1);
        check_output("reset req_ready", ready_w[1], 4'b0000);
        check_output("reset rsp_valid", rspv_w[1], 4'b0000);
        check_output("reset unit_exps", uexps_w[1], '0);
        apply_stimulus(1'b1, 4'b0000, 4'hF, zero_exps);
        check_output("idle after release", idle_w[1], 1'b1);

        // Single lane 2 with exponents 0..31
        apply_stimulus(1'b1, 4'b0100, 4'hF, ramp_exps);
        check_output("single grant", ready_w[1], 4'b0100);
        apply_stimulus(1'b1, 4'b0100, 4'hF, ramp_exps);
        check_output("single busy no regrant", ready_w[1], 4'b0000);
        check_output("single rsp not yet", rspv_w[1], 4'b0000);
        check_output("single lat0 rsp_valid", rspv_w[0], 4'b0100);
        apply_stimulus(1'b1, 4'b0100, 4'hF, ramp_exps);
        check_output("single rsp_valid", rspv_w[1], 4'b0100);
        check_output("single e_max", emax_w[1][2], 8'd31);
        check_output("single held no regrant", ready_w[1], 4'b0000);
        apply_stimulus(1'b1, 4'b0100, 4'hF, ramp_exps);
        check_output("single regrant", ready_w[1], 4'b0100);
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 4'b0000, 4'hF, ramp_exps);

        // Round robin from a fresh pointer
        apply_stimulus(1'b0, 4'b0000, 4'hF, zero_exps);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, rr_tab[k].valid, rr_tab[k].rready, pat_exps);
            check_output($sformatf("rr%0d req_ready", k), ready_w[1], rr_tab[k].exp_ready);
            check_output($sformatf("rr%0d rsp_valid", k), rspv_w[1], rr_tab[k].exp_rsp_valid);
        end

        // Backpressure on lane 1
        for (int k = 0; k < 14; k++) begin
            apply_stimulus(1'b1, 4'hF, 4'b1101, pat_exps);
            if (k >= 4) begin
                check_output("bp lane1 held valid", rspv_w[1][1], 1'b1);
                check_output("bp lane1 held e_max", emax_w[1][1], 8'd143);
                check_output("bp lane1 not regranted", ready_w[1][1], 1'b0);
                check_output("bp others one per cycle", |ready_w[1], 1'b1);
            end
        end
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 4'hF, 4'hF, pat_exps);
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 4'b0000, 4'hF, pat_exps);

        // Reset with three blocks issued and nothing consumed
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 4'hF, 4'b0000, pat_exps);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_output($sformatf("async clear rsp_valid lat%0d", lat_of(i)), rspv_w[i], '0);
            check_output($sformatf("async clear e_max lat%0d", lat_of(i)), emax_w[i], '0);
            check_output($sformatf("async clear idle lat%0d", lat_of(i)), idle_w[i], 1'b1);
        end
        @(negedge clk);
        model_step();
        apply_stimulus(1'b0, 4'b0000, 4'hF, pat_exps);
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 4'b0000, 4'hF, pat_exps);
            for (int i = 0; i < NI; i++) begin
                check_output($sformatf("no stale rsp lat%0d", lat_of(i)), rspv_w[i], '0);
            end
        end

        // Randomised traffic with random response backpressure
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] v;
            logic [N-1:0] rr;
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < L; j++) rnd_exps[r][j] = W'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) rnd_exps[r][$urandom_range(0, L-1)] = 8'hFF;
                rr[r] = ($urandom_range(0, 3) != 0);
            end
            v = N'($urandom);
            apply_stimulus(1'b1, v, rr, rnd_exps);
        end
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 4'b0000, 4'hF, zero_exps);
        for (int i = 0; i < NI; i++) begin
            check_output($sformatf("drained idle lat%0d", lat_of(i)), idle_w[i], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
